// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding/hazard scoreboard.
package fwd_pkg;

  localparam int FWD_REGW   = 5;
  localparam int FWD_NSTAGE = 3;
  localparam int FWD_RDYW   = $clog2(FWD_NSTAGE);

  // Select code meaning "take the operand from the register file".
  localparam int FWD_RF = 0;

  typedef logic [FWD_REGW-1:0] regbits_t;

  // Layout of one in-flight producer entry at the default geometry.
  typedef struct packed {
    logic                vld;
    logic                wr;
    regbits_t            dest;
    logic [FWD_RDYW-1:0] rdy;
  } fwd_entry_t;

  // Producer stage k is reached through mux input k+1 (0 is the regfile).
  function automatic int stg2sel(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Priority search of one source operand over the in-flight producer entries.
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int NSTAGE = 3,
  parameter int REGW   = 5,
  parameter int RDYW   = 2,
  parameter int SELW   = 2
) (
  input  logic [REGW-1:0]        rs_i,
  input  logic                   used_i,
  input  logic [NSTAGE-1:0]      vld_i,
  input  logic [NSTAGE-1:0]      wr_i,
  input  logic [NSTAGE*REGW-1:0] dest_i,
  input  logic [NSTAGE*RDYW-1:0] rdy_i,
  output logic [SELW-1:0]        sel_o,
  output logic                   need_stall_o
);

  logic found;

  // Youngest matching producer wins; stall if its result is not yet out.
  always_comb begin
    sel_o        = SELW'(FWD_RF);
    need_stall_o = 1'b0;
    found        = 1'b0;
    for (int k = 0; k < NSTAGE; k++) begin
      if (!found && vld_i[k] && wr_i[k] && used_i && (rs_i != '0) &&
          (dest_i[k*REGW +: REGW] == rs_i)) begin
        found = 1'b1;
        if (rdy_i[k*RDYW +: RDYW] <= RDYW'(k)) begin
          sel_o = SELW'(stg2sel(k));
        end else begin
          need_stall_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard unit: producer shift register, per-operand bypass select,
// stall generation and a saturating stall-cycle counter.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int NSRC   = 2,
  parameter int NSTAGE = 3,
  parameter int REGW   = 5,
  parameter int CNTW   = 16,
  localparam int SELW  = $clog2(NSTAGE + 1),
  localparam int RDYW  = (NSTAGE > 1) ? $clog2(NSTAGE) : 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 id_valid,
  input  logic [NSRC*REGW-1:0] id_rs,
  input  logic [NSRC-1:0]      id_rs_used,
  input  logic [REGW-1:0]      id_dest,
  input  logic                 id_regwr,
  input  logic [RDYW-1:0]      id_rdy_stg,
  input  logic                 flush,
  output logic [NSRC*SELW-1:0] fwd_sel,
  output logic                 stall,
  output logic [CNTW-1:0]      stall_cycles
);

  logic [NSTAGE-1:0]      vld_q,  vld_d;
  logic [NSTAGE-1:0]      wr_q,   wr_d;
  logic [NSTAGE*REGW-1:0] dest_q, dest_d;
  logic [NSTAGE*RDYW-1:0] rdy_q,  rdy_d;
  logic [CNTW-1:0]        cnt_q,  cnt_d;

  logic [NSRC*SELW-1:0]   sel_raw;
  logic [NSRC-1:0]        need_stall;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    fwd_src_match #(
      .NSTAGE (NSTAGE),
      .REGW   (REGW),
      .RDYW   (RDYW),
      .SELW   (SELW)
    ) u_match (
      .rs_i         (id_rs[i*REGW +: REGW]),
      .used_i       (id_rs_used[i]),
      .vld_i        (vld_q),
      .wr_i         (wr_q),
      .dest_i       (dest_q),
      .rdy_i        (rdy_q),
      .sel_o        (sel_raw[i*SELW +: SELW]),
      .need_stall_o (need_stall[i])
    );
  end

  // A squashed slot must never hold the front end, and idle decode reports zeros.
  assign stall        = id_valid & (|need_stall) & ~flush;
  assign fwd_sel      = id_valid ? sel_raw : '0;
  assign stall_cycles = cnt_q;

  // Age every entry by one stage; decode fills e[0] unless squashed or held.
  always_comb begin
    vld_d  = vld_q;
    wr_d   = wr_q;
    dest_d = dest_q;
    rdy_d  = rdy_q;
    for (int k = NSTAGE - 1; k >= 1; k--) begin
      vld_d[k]                = vld_q[k-1];
      wr_d[k]                 = wr_q[k-1];
      dest_d[k*REGW +: REGW]  = dest_q[(k-1)*REGW +: REGW];
      rdy_d[k*RDYW +: RDYW]   = rdy_q[(k-1)*RDYW +: RDYW];
    end
    vld_d[0]         = id_valid & ~flush & ~stall;
    wr_d[0]          = id_regwr & (id_dest != '0);
    dest_d[0 +: REGW] = id_dest;
    rdy_d[0 +: RDYW]  = id_rdy_stg;
  end

  // Stall counter sticks at all ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Entry and counter registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_q  <= '0;
      wr_q   <= '0;
      dest_q <= '0;
      rdy_q  <= '0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      wr_q   <= wr_d;
      dest_q <= dest_d;
      rdy_q  <= rdy_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: pipeline-level model plus directed cases.
module tb_fwd_scoreboard;

  localparam int NSRC   = 2;
  localparam int NSTAGE = 3;
  localparam int REGW   = 5;
  localparam int CNTW   = 10;
  localparam int SELW   = 2;
  localparam int RDYW   = 2;
  localparam int CMAX   = (1 << CNTW) - 1;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic                 id_valid;
  logic [NSRC*REGW-1:0] id_rs;
  logic [NSRC-1:0]      id_rs_used;
  logic [REGW-1:0]      id_dest;
  logic                 id_regwr;
  logic [RDYW-1:0]      id_rdy_stg;
  logic                 flush;
  logic [NSRC*SELW-1:0] fwd_sel;
  logic                 stall;
  logic [CNTW-1:0]      stall_cycles;

  fwd_scoreboard #(
    .NSRC   (NSRC),
    .NSTAGE (NSTAGE),
    .REGW   (REGW),
    .CNTW   (CNTW)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rs_used   (id_rs_used),
    .id_dest      (id_dest),
    .id_regwr     (id_regwr),
    .id_rdy_stg   (id_rdy_stg),
    .flush        (flush),
    .fwd_sel      (fwd_sel),
    .stall        (stall),
    .stall_cycles (stall_cycles)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // Model: list of in-flight producers, index = stages past decode.
  bit m_vld [NSTAGE];
  bit m_wr  [NSTAGE];
  int m_dest[NSTAGE];
  int m_rdy [NSTAGE];
  int m_cnt;
  int exp_sel[NSRC];
  bit exp_stall;
  logic [NSRC*SELW-1:0] exp_vec;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Expected outputs for the current decode instruction from the producer list.
  function automatic void model_eval();
    bit any_need;
    any_need = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      int rs;
      rs = int'(id_rs[i*REGW +: REGW]);
      exp_sel[i] = 0;
      if (id_rs_used[i] && rs != 0) begin
        for (int k = 0; k < NSTAGE; k++) begin
          if (m_vld[k] && m_wr[k] && m_dest[k] == rs) begin
            if (m_rdy[k] > k) any_need = 1'b1;
            else exp_sel[i] = k + 1;
            break;
          end
        end
      end
      if (!id_valid) exp_sel[i] = 0;
    end
    exp_stall = id_valid && any_need && !flush;
    for (int i = 0; i < NSRC; i++) exp_vec[i*SELW +: SELW] = SELW'(exp_sel[i]);
  endfunction

  // Advance the model one clock.
  always @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < NSTAGE; k++) begin
        m_vld[k] = 1'b0; m_wr[k] = 1'b0; m_dest[k] = 0; m_rdy[k] = 0;
      end
      m_cnt = 0;
    end else begin
      model_eval();
      if (exp_stall && m_cnt < CMAX) m_cnt = m_cnt + 1;
      for (int k = NSTAGE - 1; k >= 1; k--) begin
        m_vld[k] = m_vld[k-1]; m_wr[k] = m_wr[k-1];
        m_dest[k] = m_dest[k-1]; m_rdy[k] = m_rdy[k-1];
      end
      m_vld[0]  = id_valid && !flush && !exp_stall;
      m_wr[0]   = id_regwr && id_dest != 0;
      m_dest[0] = int'(id_dest);
      m_rdy[0]  = int'(id_rdy_stg);
    end
    started = 1'b1;
  end

  // Compare DUT against the model every cycle, mid-period.
  always @(negedge CLK) begin
    if (started) begin
      model_eval();
      chk("model fwd_sel", 32'(fwd_sel), 32'(exp_vec));
      chk("model stall", 32'(stall), 32'(exp_stall));
      chk("model stall_cycles", 32'(stall_cycles), 32'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input bit v, input int rs0, input int rs1, input bit u0, input bit u1,
                       input int dest, input bit wr, input int rdy, input bit fl);
    id_valid   = v;
    id_rs      = {REGW'(rs1), REGW'(rs0)};
    id_rs_used = {u1, u0};
    id_dest    = REGW'(dest);
    id_regwr   = wr;
    id_rdy_stg = RDYW'(rdy);
    flush      = fl;
  endtask

  task automatic drain();
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  initial begin
    RST = 1'b1;
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    chk("reset fwd_sel", 32'(fwd_sel), 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset stall_cycles", 32'(stall_cycles), 32'd0);
    RST = 1'b0;
    tick();

    // ADD r3; SUB r4,r3,r1 forwards from EX; OR r5,r3,r0 forwards from MEM.
    issue(1, 1, 2, 1, 1, 3, 1, 0, 0); tick();
    issue(1, 3, 1, 1, 1, 4, 1, 0, 0); #2;
    chk("alu fwd ex", 32'(fwd_sel), 32'h1);
    chk("alu no stall", 32'(stall), 32'd0);
    tick();
    issue(1, 3, 0, 1, 1, 5, 1, 0, 0); #2;
    chk("alu fwd mem", 32'(fwd_sel), 32'h2);
    tick(); drain();

    // LW r2; ADD r6,r2,r2 stalls one cycle then both operands from MEM.
    issue(1, 0, 0, 0, 0, 2, 1, 1, 0); tick();
    issue(1, 2, 2, 1, 1, 6, 1, 0, 0); #2;
    chk("load-use stall", 32'(stall), 32'd1);
    chk("load-use sel during stall", 32'(fwd_sel), 32'd0);
    tick(); #2;
    chk("load-use released", 32'(stall), 32'd0);
    chk("load-use fwd mem", 32'(fwd_sel), 32'hA);
    chk("load-use count", 32'(stall_cycles), 32'd1);
    tick(); drain();

    // Writer of r0 never forwards.
    issue(1, 1, 1, 1, 1, 0, 1, 0, 0); tick();
    issue(1, 0, 0, 1, 1, 9, 1, 0, 0); #2;
    chk("r0 sel", 32'(fwd_sel), 32'd0);
    chk("r0 stall", 32'(stall), 32'd0);
    tick(); drain();

    // ADD r7 then ADDI r7: youngest producer wins.
    issue(1, 1, 1, 1, 1, 7, 1, 0, 0); tick();
    issue(1, 1, 0, 1, 0, 7, 1, 0, 0); tick();
    issue(1, 7, 7, 1, 1, 10, 1, 0, 0); #2;
    chk("youngest wins", 32'(fwd_sel), 32'h5);
    tick(); drain();

    // LW r2 then consumer (dest r9) squashed by flush.
    issue(1, 0, 0, 0, 0, 2, 1, 1, 0); tick();
    issue(1, 2, 0, 1, 0, 9, 1, 0, 1); #2;
    chk("flush beats stall", 32'(stall), 32'd0);
    tick();
    issue(1, 2, 9, 1, 1, 11, 1, 0, 0); #2;
    chk("after flush sel", 32'(fwd_sel), 32'h2);
    chk("after flush count", 32'(stall_cycles), 32'd1);
    tick(); drain();

    // Producer ready in WB stalls a dependent for two cycles.
    issue(1, 0, 0, 0, 0, 8, 1, 2, 0); tick();
    issue(1, 8, 0, 1, 0, 12, 1, 0, 0); #2;
    chk("late stall 1", 32'(stall), 32'd1);
    tick(); #2;
    chk("late stall 2", 32'(stall), 32'd1);
    tick(); #2;
    chk("late release", 32'(stall), 32'd0);
    chk("late fwd wb", 32'(fwd_sel), 32'h3);
    chk("late count", 32'(stall_cycles), 32'd3);
    tick(); drain();

    // Chain of r2<-r2 slow ops saturates the counter, then reset mid-stall.
    issue(1, 2, 2, 1, 1, 2, 1, 2, 0);
    repeat (1600) tick();
    #2;
    chk("counter saturated", 32'(stall_cycles), 32'(CMAX));
    begin
      bit hit;
      hit = 1'b0;
      for (int n = 0; n < 4; n++) begin
        model_eval();
        if (exp_stall) begin hit = 1'b1; break; end
        tick(); #2;
      end
      chk("reached stall before reset", 32'(hit), 32'd1);
    end
    chk("stall before reset", 32'(stall), 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #2;
    chk("post-reset stall", 32'(stall), 32'd0);
    chk("post-reset sel", 32'(fwd_sel), 32'd0);
    chk("post-reset count", 32'(stall_cycles), 32'd0);
    tick(); drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
